fetch: RTL and testbench

Instruction fetch stage of the RISC-V core, directly upstream of `decode`. It owns the program counter and issues word reads to a synchronous instruction memory with fixed one-cycle read latency. It buffers returned words in a 2-entry FIFO and presents `inst` plus its `pc` to decode over a valid/ready handshake. On a taken branch or jump (redirect), it flushes all buffered and in-flight words and restarts from the target.

---
 rtl/fetch_if.sv | 20 ++
 rtl/fetch.sv | 68 ++++++
 tb/tb_fetch.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_if.sv
// fetch_if: instruction-memory, redirect and decode-side signals of the fetch stage.
interface fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] inst;
  logic [31:0] pc;
  logic        inst_valid;
  logic        inst_ready;
  modport master (
    output imem_req, imem_addr, inst, pc, inst_valid,
    input  imem_rdata, redirect_valid, redirect_pc, inst_ready
  );
  modport slave (
    input  imem_req, imem_addr, inst, pc, inst_valid,
    output imem_rdata, redirect_valid, redirect_pc, inst_ready
  );
endinterface

// File: rtl/fetch.sv
// fetch: owns the PC, issues 1-cycle-latency imem reads, buffers words in a 2-entry FIFO for decode.
module fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic    clk,
  input  logic    rst,
  fetch_if.master bus
);
  localparam logic [31:0] BOOT_PC = RESET_PC & ~32'h3;
  logic [31:0] pc_next_q, pc_next_d;
  logic [31:0] inst0_q, inst0_d, inst1_q, inst1_d;
  logic [31:0] pc0_q, pc0_d, pc1_q, pc1_d;
  logic [1:0]  count_q, count_d;
  logic        inflight_q;
  logic [31:0] inflight_pc_q;
  logic        redir, valid, pop, push, req;
  logic [2:0]  occ;
  logic [1:0]  wpos;
  logic [31:0] addr;
  always_comb begin
    redir = bus.redirect_valid && !rst;
    valid = (count_q != 2'd0) && !redir && !rst;
    pop   = valid && bus.inst_ready;
    push  = inflight_q && !redir;
    // Slots already promised: buffered words plus the one still in flight, minus what leaves now.
    occ   = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
    req   = !rst && (redir || occ < 3'd2);
    addr  = redir ? (bus.redirect_pc & ~32'h3) : pc_next_q;
    pc_next_d = req ? addr + 32'd4 : pc_next_q;
    wpos    = count_q - {1'b0, pop};
    count_d = redir ? 2'd0 : count_q + {1'b0, push} - {1'b0, pop};
    // Slot 0 is the head; it only shifts when a second word is behind it, so the outputs hold when empty.
    inst0_d = (pop && count_q == 2'd2) ? inst1_q : inst0_q;
    pc0_d   = (pop && count_q == 2'd2) ? pc1_q : pc0_q;
    inst1_d = inst1_q;
    pc1_d   = pc1_q;
    inst0_d = (push && wpos == 2'd0) ? bus.imem_rdata : inst0_d;
    pc0_d   = (push && wpos == 2'd0) ? inflight_pc_q : pc0_d;
    inst1_d = (push && wpos == 2'd1) ? bus.imem_rdata : inst1_d;
    pc1_d   = (push && wpos == 2'd1) ? inflight_pc_q : pc1_d;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_next_q     <= BOOT_PC;
      count_q       <= 2'd0;
      inflight_q    <= 1'b0;
      inflight_pc_q <= 32'd0;
      inst0_q       <= 32'd0;
      inst1_q       <= 32'd0;
      pc0_q         <= 32'd0;
      pc1_q         <= 32'd0;
    end else begin
      pc_next_q     <= pc_next_d;
      count_q       <= count_d;
      inflight_q    <= req;
      inflight_pc_q <= req ? addr : inflight_pc_q;
      inst0_q       <= inst0_d;
      inst1_q       <= inst1_d;
      pc0_q         <= pc0_d;
      pc1_q         <= pc1_d;
    end
  end
  assign bus.imem_req   = req;
  assign bus.imem_addr  = addr;
  assign bus.inst       = inst0_q;
  assign bus.pc         = pc0_q;
  assign bus.inst_valid = valid;
endmodule

// File: tb/tb_fetch.sv
// tb_fetch: directed checks of fetch startup, streaming, backpressure, redirects, reset and PC wrap.
module tb_fetch;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst2 = 1'b1;
  logic mode = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [31:0] tbl [4] = '{32'h002081b3, 32'h05408113, 32'h000230B7, 32'hfe111ce3};
  fetch_if f ();
  fetch_if g ();
  fetch dut (.clk(clk), .rst(rst), .bus(f.master));
  fetch #(.RESET_PC(32'hFFFF_FFF8)) dut2 (.clk(clk), .rst(rst2), .bus(g.master));
  always #5 clk = ~clk;
  function automatic logic [31:0] mem_word(input logic m, input logic [31:0] a);
    if (m && a < 32'h10) return tbl[a[3:2]];
    return a;
  endfunction
  always_ff @(posedge clk) f.imem_rdata <= mem_word(mode, f.imem_addr);
  always_ff @(posedge clk) g.imem_rdata <= g.imem_addr;
  task automatic restart;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask
  task automatic test_reset;
    f.inst_ready = 1'b1; f.redirect_valid = 1'b0; f.redirect_pc = 32'd0; mode = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (f.inst_valid !== 1'b0 || f.imem_req !== 1'b0 || f.imem_addr !== 32'd0 || f.inst !== 32'd0 || f.pc !== 32'd0) begin
      errors++;
      $display("FAIL reset_state: valid=%b req=%b addr=%h inst=%h pc=%h, expected 0 0 0 0 0", f.inst_valid, f.imem_req, f.imem_addr, f.inst, f.pc);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (f.imem_req !== 1'b1 || f.imem_addr !== 32'd0) begin
      errors++;
      $display("FAIL first_req: req=%b addr=%h, expected 1 00000000", f.imem_req, f.imem_addr);
    end
    @(negedge clk); #1;
    checks++;
    if (f.inst_valid !== 1'b0) begin
      errors++;
      $display("FAIL startup_gap: valid=%b, expected 0", f.inst_valid);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      checks++;
      if (f.inst_valid !== 1'b1 || f.pc !== 32'(4 * i) || f.inst !== 32'(4 * i)) begin
        errors++;
        $display("FAIL startup_word%0d: valid=%b pc=%h inst=%h, expected 1 %h %h", i, f.inst_valid, f.pc, f.inst, 32'(4 * i), 32'(4 * i));
      end
    end
  endtask
  task automatic test_stream;
    mode = 1'b1; f.inst_ready = 1'b1;
    restart();
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      checks++;
      if (f.inst_valid !== 1'b1 || f.pc !== 32'(4 * i) || f.inst !== tbl[i]) begin
        errors++;
        $display("FAIL stream%0d: valid=%b pc=%h inst=%h, expected 1 %h %h", i, f.inst_valid, f.pc, f.inst, 32'(4 * i), tbl[i]);
      end
    end
    mode = 1'b0;
  endtask
  task automatic test_backpressure;
    logic [31:0] exp_pc;
    exp_pc = 32'd0;
    f.inst_ready = 1'b1;
    restart();
    for (int c = 0; c < 10; c++) begin
      if (c > 0) @(negedge clk);
      f.inst_ready = !(c >= 2 && c <= 4);
      #1;
      checks++;
      if (f.inst_valid !== 1'b1 || f.pc !== exp_pc) begin
        errors++;
        $display("FAIL bp_seq c%0d: valid=%b pc=%h, expected 1 %h", c, f.inst_valid, f.pc, exp_pc);
      end
      if (c >= 2 && c <= 4) begin
        checks++;
        if (f.imem_req !== 1'b0) begin
          errors++;
          $display("FAIL bp_req c%0d: req=%b, expected 0", c, f.imem_req);
        end
      end
      if (f.inst_ready) exp_pc = exp_pc + 32'd4;
    end
    f.inst_ready = 1'b1;
  endtask
  task automatic test_redirect;
    f.inst_ready = 1'b1;
    restart();
    @(negedge clk);
    @(negedge clk); #1;
    checks++;
    if (f.inst_valid !== 1'b1 || f.pc !== 32'h8) begin
      errors++;
      $display("FAIL redir_pre: valid=%b pc=%h, expected 1 00000008", f.inst_valid, f.pc);
    end
    f.redirect_valid = 1'b1; f.redirect_pc = 32'h40;
    #1;
    checks++;
    if (f.inst_valid !== 1'b0 || f.imem_req !== 1'b1 || f.imem_addr !== 32'h40) begin
      errors++;
      $display("FAIL redir_cycle: valid=%b req=%b addr=%h, expected 0 1 00000040", f.inst_valid, f.imem_req, f.imem_addr);
    end
    @(negedge clk);
    f.redirect_valid = 1'b0;
    #1;
    checks++;
    if (f.inst_valid !== 1'b0) begin
      errors++;
      $display("FAIL redir_flush: valid=%b pc=%h, expected valid 0", f.inst_valid, f.pc);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      checks++;
      if (f.inst_valid !== 1'b1 || f.pc !== 32'(32'h40 + 4 * i) || f.inst !== 32'(32'h40 + 4 * i)) begin
        errors++;
        $display("FAIL redir_target%0d: valid=%b pc=%h inst=%h, expected 1 %h", i, f.inst_valid, f.pc, f.inst, 32'(32'h40 + 4 * i));
      end
    end
  endtask
  task automatic test_stall_redirect;
    f.inst_ready = 1'b0;
    restart();
    @(negedge clk);
    @(negedge clk); #1;
    checks++;
    if (f.inst_valid !== 1'b1 || f.pc !== 32'd0 || f.imem_req !== 1'b0) begin
      errors++;
      $display("FAIL stall_full: valid=%b pc=%h req=%b, expected 1 00000000 0", f.inst_valid, f.pc, f.imem_req);
    end
    f.redirect_valid = 1'b1; f.redirect_pc = 32'h103;
    #1;
    checks++;
    if (f.imem_addr !== 32'h100 || f.imem_req !== 1'b1 || f.inst_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_redir: addr=%h req=%b valid=%b, expected 00000100 1 0", f.imem_addr, f.imem_req, f.inst_valid);
    end
    @(negedge clk);
    f.redirect_valid = 1'b0;
    #1;
    checks++;
    if (f.inst_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_empty: valid=%b pc=%h, expected valid 0", f.inst_valid, f.pc);
    end
    @(negedge clk); #1;
    checks++;
    if (f.inst_valid !== 1'b1 || f.pc !== 32'h100 || f.inst !== 32'h100) begin
      errors++;
      $display("FAIL stall_target: valid=%b pc=%h inst=%h, expected 1 00000100 00000100", f.inst_valid, f.pc, f.inst);
    end
    f.inst_ready = 1'b1;
    @(negedge clk); #1;
    checks++;
    if (f.inst_valid !== 1'b1 || f.pc !== 32'h104) begin
      errors++;
      $display("FAIL stall_next: valid=%b pc=%h, expected 1 00000104", f.inst_valid, f.pc);
    end
  endtask
  task automatic test_reset_midstream;
    f.inst_ready = 1'b1;
    restart();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1; f.redirect_valid = 1'b1; f.redirect_pc = 32'h80;
    #1;
    checks++;
    if (f.imem_req !== 1'b0) begin
      errors++;
      $display("FAIL midrst_req: req=%b, expected 0", f.imem_req);
    end
    @(negedge clk);
    rst = 1'b0; f.redirect_valid = 1'b0;
    #1;
    checks++;
    if (f.inst_valid !== 1'b0 || f.imem_req !== 1'b1 || f.imem_addr !== 32'd0) begin
      errors++;
      $display("FAIL midrst_restart: valid=%b req=%b addr=%h, expected 0 1 00000000", f.inst_valid, f.imem_req, f.imem_addr);
    end
    @(negedge clk); #1;
    checks++;
    if (f.inst_valid !== 1'b0) begin
      errors++;
      $display("FAIL midrst_stale: valid=%b pc=%h, expected valid 0", f.inst_valid, f.pc);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      checks++;
      if (f.inst_valid !== 1'b1 || f.pc !== 32'(4 * i)) begin
        errors++;
        $display("FAIL midrst_word%0d: valid=%b pc=%h, expected 1 %h", i, f.inst_valid, f.pc, 32'(4 * i));
      end
    end
  endtask
  task automatic test_wrap;
    logic [31:0] exp_pc [3];
    exp_pc = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
    rst2 = 1'b0;
    #1;
    checks++;
    if (g.imem_req !== 1'b1 || g.imem_addr !== 32'hFFFF_FFF8) begin
      errors++;
      $display("FAIL wrap_first: req=%b addr=%h, expected 1 fffffff8", g.imem_req, g.imem_addr);
    end
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      checks++;
      if (g.inst_valid !== 1'b1 || g.pc !== exp_pc[i] || g.inst !== exp_pc[i]) begin
        errors++;
        $display("FAIL wrap%0d: valid=%b pc=%h inst=%h, expected 1 %h", i, g.inst_valid, g.pc, g.inst, exp_pc[i]);
      end
    end
  endtask
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end
  initial begin
    f.inst_ready = 1'b1; f.redirect_valid = 1'b0; f.redirect_pc = 32'd0;
    g.inst_ready = 1'b1; g.redirect_valid = 1'b0; g.redirect_pc = 32'd0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_stall_redirect();
    test_reset_midstream();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
